tlb_unit: RTL and testbench
===========================

# tlb_unit

Parametrised, fully associative MIPS32 joint TLB with registered lookup, probe (TLBP), read (TLBR), indexed/random write (TLBWI/TLBWR) and a Wired-aware Random counter. It replaces the fixed 16-entry combinational translation inside the memory management path. It sits between the MEM-stage address generator and the SRAM/UART address decode, and serves CP0 for TLB instructions.

## Interface
- ENTRIES, 16, number of TLB entries (power of two, 2..64)
- IDX_W, $clog2(ENTRIES), index width
- ASID_W, 8, ASID width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- lk_req  in  1  lookup request
- lk_vaddr  in  32  virtual address
- lk_store  in  1  request is a store
- asid_i  in  ASID_W  current ASID (EntryHi[7:0])
- lk_valid  out  1  lookup result valid
- lk_paddr  out  32  physical address
- lk_miss  out  1  TLB refill miss
- lk_invalid  out  1  matched page V=0 (macro-dependent)
- lk_modified  out  1  store to page D=0 (macro-dependent)
- wr_en  in  1  write strobe (TLBWI/TLBWR)
- wr_random  in  1  1: write at random_o; 0: write at index_i
- index_i  in  IDX_W  CP0 Index
- entryhi_i, entrylo0_i, entrylo1_i  in  32  CP0 sources
- wired_i  in  IDX_W  CP0 Wired
- wired_we  in  1  Wired being written this cycle
- probe_req  in  1  TLBP
- probe_miss  out  1  probe found no match (Index[31])
- probe_index  out  IDX_W  matching index
- probe_valid  out  1  probe result valid
- rd_req  in  1  TLBR at index_i
- rd_entryhi, rd_entrylo0, rd_entrylo1  out  32  read result
- rd_valid  out  1  read result valid
- random_o  out  IDX_W  CP0 Random

## Operation
- Entry fields: VPN2=entryhi[31:13], ASID=entryhi[ASID_W-1:0], G=lo0[0]&lo1[0], PFNx=lox[25:6] (20 bits), Cx=lox[5:3], Dx=lox[2], Vx=lox[1], plus a per-entry `used` bit.
- Match: used & VPN2==vaddr[31:13] & (G | ASID==asid_i). Multiple matches resolve to the lowest index.
- Page select: vaddr[12]=0 selects PFN0/D0/V0; vaddr[12]=1 selects PFN1/D1/V1. lk_paddr={PFN,vaddr[11:0]}.
- Unmapped: vaddr>=0x8000_0000 bypasses the TLB. lk_paddr={3'b0,vaddr[28:0]}; miss, invalid and modified are all 0.
- Miss: lk_miss=1, lk_paddr=0.
- Write: stores fields into entry (wr_random ? random_o : index_i) and sets used=1.
- Read: rd_entryhi={VPN2,5'b0,ASID}. rd_entrylo0/1={6'b0,PFN,C,D,V,G}. An unused entry reads all zeros.
- Probe: matches against entryhi_i VPN2/ASID.
- Random counter:
  - Decrements every cycle.
  - When random_o<=wired_i, the next value is ENTRIES-1.
  - wired_we sets it to ENTRIES-1.
  - A wr_en with wr_random=1 does not stall the counter.

## Timing
- Reset values:
  - All used bits = 0.
  - random_o = ENTRIES-1.
  - Every valid output = 0; every data output = 0.
- Lookup, probe and read each have 1-cycle latency. A request at edge N gives a result at N+1, with its valid flag high for exactly one cycle. Requests may issue back-to-back every cycle.
- Write at edge N is visible to any lookup, probe or read issued at N+1 or later. A request issued in the same cycle as the write sees the old contents.
- lk_req, probe_req and rd_req are independent and may coincide.
- rst asserted mid-operation drops every in-flight result: no valid pulse follows the reset cycle.
- Output data holds its last value while the corresponding valid flag is 0.

## Configuration
- TLB_PERM_CHECK_EN defined:
  - lk_invalid=1 when the selected V=0.
  - lk_modified=1 when lk_store & V=1 & D=0.
  - On either flag, lk_paddr=0.
  - lk_miss takes precedence over both flags.
- TLB_PERM_CHECK_EN undefined:
  - lk_invalid and lk_modified are constant 0.
  - V and D are stored and readable via TLBR but ignored on lookup.

## Test plan
- Reset, then lookup 0x0040_0000 -> next cycle lk_valid=1, lk_miss=1, lk_paddr=0. Lookup 0x8000_1234 -> lk_paddr=0x0000_1234, lk_miss=0.
- TLBWI index 3: entryhi=0x0040_0005, lo0=0x0000_0107 (PFN 4, D=1, V=1, G=1), lo1=0x0000_0147 (PFN 5). Then lookup 0x0040_1ABC with asid 0x09 -> lk_paddr=0x0000_5ABC (global entry, odd page).
- Same write with G=0: asid 0x05 -> hit; asid 0x06 -> lk_miss=1. Probe with entryhi 0x0040_0005 -> probe_index=3, probe_miss=0.
- wired_i=4, ENTRIES=16: random_o cycles 15..4 and then wraps to 15. wired_we mid-sequence forces 15 next cycle. TLBWR stores to the current random_o, confirmed by TLBR.
- Write and lookup of the same VPN issued in the same cycle -> lk_miss=1. Repeated lookup next cycle -> hit.
- With TLB_PERM_CHECK_EN: page with V=1, D=0, store -> lk_modified=1, lk_paddr=0. Load to the same page -> hit. Page with V=0 -> lk_invalid=1.

Source files
------------

// File: rtl/tlb_unit.sv
// tlb_unit: fully associative MIPS32 joint TLB.
// Provides a registered address lookup for the MEM stage, plus the TLBP probe,
// TLBR read, TLBWI/TLBWR write and the Wired-aware Random register for CP0.
// Optional feature macro: TLB_PERM_CHECK_EN enables the V/D permission checks
// on lookup (lk_invalid / lk_modified). Without it, V and D are stored and
// readable through TLBR but do not affect translation.
module tlb_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int ASID_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    // MEM-stage lookup
    input  logic              lk_req,
    input  logic [31:0]       lk_vaddr,
    input  logic              lk_store,
    input  logic [ASID_W-1:0] asid_i,
    output logic              lk_valid,
    output logic [31:0]       lk_paddr,
    output logic              lk_miss,
    output logic              lk_invalid,
    output logic              lk_modified,
    // TLBWI / TLBWR
    input  logic              wr_en,
    input  logic              wr_random,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [31:0]       entryhi_i,
    input  logic [31:0]       entrylo0_i,
    input  logic [31:0]       entrylo1_i,
    input  logic [IDX_W-1:0]  wired_i,
    input  logic              wired_we,
    // TLBP
    input  logic              probe_req,
    output logic              probe_miss,
    output logic [IDX_W-1:0]  probe_index,
    output logic              probe_valid,
    // TLBR
    input  logic              rd_req,
    output logic [31:0]       rd_entryhi,
    output logic [31:0]       rd_entrylo0,
    output logic [31:0]       rd_entrylo1,
    output logic              rd_valid,
    // CP0 Random
    output logic [IDX_W-1:0]  random_o
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ENTRIES - 1);

    // Entry storage; only the used bits need a reset value.
    logic [18:0]        vpn2_q [ENTRIES];
    logic [ASID_W-1:0]  asid_q [ENTRIES];
    logic [19:0]        pfn0_q [ENTRIES];
    logic [19:0]        pfn1_q [ENTRIES];
    logic [2:0]         c0_q   [ENTRIES];
    logic [2:0]         c1_q   [ENTRIES];
    logic [ENTRIES-1:0] g_q;
    logic [ENTRIES-1:0] d0_q;
    logic [ENTRIES-1:0] d1_q;
    logic [ENTRIES-1:0] v0_q;
    logic [ENTRIES-1:0] v1_q;
    logic [ENTRIES-1:0] used_q;

    logic [IDX_W-1:0]   random_q;
    logic [IDX_W-1:0]   wr_idx;

    logic [ENTRIES-1:0] lk_match;
    logic [ENTRIES-1:0] pb_match;
    logic [IDX_W-1:0]   lk_hit_idx;
    logic [19:0]        sel_pfn;
    logic               sel_v;
    logic               sel_d;
    logic [31:0]        lk_paddr_d;
    logic               lk_miss_d;
    logic               lk_inv_d;
    logic               lk_mod_d;

    logic [31:0]        rd_hi_d;
    logic [31:0]        rd_lo0_d;
    logic [31:0]        rd_lo1_d;

    // Lowest set bit wins when several entries match.
    function automatic logic [IDX_W-1:0] first_set(input logic [ENTRIES-1:0] vec);
        first_set = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) first_set = IDX_W'(i);
        end
    endfunction

    assign random_o = random_q;
    assign wr_idx   = wr_random ? random_q : index_i;

    // Entry writes; reset only invalidates, field contents are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
        end else if (wr_en) begin
            used_q[wr_idx] <= 1'b1;
            vpn2_q[wr_idx] <= entryhi_i[31:13];
            asid_q[wr_idx] <= entryhi_i[ASID_W-1:0];
            g_q[wr_idx]    <= entrylo0_i[0] & entrylo1_i[0];
            pfn0_q[wr_idx] <= entrylo0_i[25:6];
            c0_q[wr_idx]   <= entrylo0_i[5:3];
            d0_q[wr_idx]   <= entrylo0_i[2];
            v0_q[wr_idx]   <= entrylo0_i[1];
            pfn1_q[wr_idx] <= entrylo1_i[25:6];
            c1_q[wr_idx]   <= entrylo1_i[5:3];
            d1_q[wr_idx]   <= entrylo1_i[2];
            v1_q[wr_idx]   <= entrylo1_i[1];
        end
    end

    // Random counts down and reloads to the top once it reaches Wired.
    always_ff @(posedge clk) begin
        if (rst || wired_we || (random_q <= wired_i)) begin
            random_q <= TOP_IDX;
        end else begin
            random_q <= random_q - IDX_W'(1);
        end
    end

    // Associative compare for the lookup port and the probe port.
    always_comb begin
        lk_match = '0;
        pb_match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_match[i] = used_q[i] && (vpn2_q[i] == lk_vaddr[31:13]) &&
                          (g_q[i] || (asid_q[i] == asid_i));
            pb_match[i] = used_q[i] && (vpn2_q[i] == entryhi_i[31:13]) &&
                          (g_q[i] || (asid_q[i] == entryhi_i[ASID_W-1:0]));
        end
    end

    // Translation: kseg bypass, refill miss, or even/odd page of the hit entry.
    always_comb begin
        lk_hit_idx = first_set(lk_match);
        sel_pfn    = lk_vaddr[12] ? pfn1_q[lk_hit_idx] : pfn0_q[lk_hit_idx];
        sel_v      = lk_vaddr[12] ? v1_q[lk_hit_idx]   : v0_q[lk_hit_idx];
        sel_d      = lk_vaddr[12] ? d1_q[lk_hit_idx]   : d0_q[lk_hit_idx];
        lk_paddr_d = '0;
        lk_miss_d  = 1'b0;
        lk_inv_d   = 1'b0;
        lk_mod_d   = 1'b0;
        if (lk_vaddr[31]) begin
            lk_paddr_d = {3'b000, lk_vaddr[28:0]};
        end else if (lk_match == '0) begin
            lk_miss_d = 1'b1;
        end else begin
`ifdef TLB_PERM_CHECK_EN
            lk_inv_d = ~sel_v;
            lk_mod_d = lk_store & sel_v & ~sel_d;
            if (!(lk_inv_d || lk_mod_d)) begin
                lk_paddr_d = {sel_pfn, lk_vaddr[11:0]};
            end
`else
            lk_paddr_d = {sel_pfn, lk_vaddr[11:0]};
`endif
        end
    end

    // TLBR formatting; an entry never written reads back as zeros.
    always_comb begin
        rd_hi_d  = '0;
        rd_lo0_d = '0;
        rd_lo1_d = '0;
        if (used_q[index_i]) begin
            rd_hi_d  = {vpn2_q[index_i], {(13 - ASID_W){1'b0}}, asid_q[index_i]};
            rd_lo0_d = {6'b0, pfn0_q[index_i], c0_q[index_i], d0_q[index_i],
                        v0_q[index_i], g_q[index_i]};
            rd_lo1_d = {6'b0, pfn1_q[index_i], c1_q[index_i], d1_q[index_i],
                        v1_q[index_i], g_q[index_i]};
        end
    end

    // Lookup result register; data holds between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_valid    <= 1'b0;
            lk_paddr    <= '0;
            lk_miss     <= 1'b0;
            lk_invalid  <= 1'b0;
            lk_modified <= 1'b0;
        end else begin
            lk_valid <= lk_req;
            if (lk_req) begin
                lk_paddr    <= lk_paddr_d;
                lk_miss     <= lk_miss_d;
                lk_invalid  <= lk_inv_d;
                lk_modified <= lk_mod_d;
            end
        end
    end

    // Probe result register; index reads 0 on a probe miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_valid <= 1'b0;
            probe_miss  <= 1'b0;
            probe_index <= '0;
        end else begin
            probe_valid <= probe_req;
            if (probe_req) begin
                probe_miss  <= (pb_match == '0);
                probe_index <= first_set(pb_match);
            end
        end
    end

    // Read result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid    <= 1'b0;
            rd_entryhi  <= '0;
            rd_entrylo0 <= '0;
            rd_entrylo1 <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_entryhi  <= rd_hi_d;
                rd_entrylo0 <= rd_lo0_d;
                rd_entrylo1 <= rd_lo1_d;
            end
        end
    end

    // Inputs bits that carry no state in this TLB, and V/D when checks are off.
    logic unused_bits;
    assign unused_bits = ^{entryhi_i[12:ASID_W], entrylo0_i[31:26],
                           entrylo1_i[31:26], sel_v, sel_d, lk_store};

endmodule

// File: tb/tb_tlb_unit.sv
// Bench for tlb_unit: directed steps followed by a random phase, all checked
// against a reference model holding raw CP0 register images per entry.
module tb_tlb_unit;

    localparam int E = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_req;
    logic [31:0] lk_vaddr;
    logic        lk_store;
    logic [7:0]  asid_i;
    logic        lk_valid;
    logic [31:0] lk_paddr;
    logic        lk_miss;
    logic        lk_invalid;
    logic        lk_modified;
    logic        wr_en;
    logic        wr_random;
    logic [3:0]  index_i;
    logic [31:0] entryhi_i;
    logic [31:0] entrylo0_i;
    logic [31:0] entrylo1_i;
    logic [3:0]  wired_i;
    logic        wired_we;
    logic        probe_req;
    logic        probe_miss;
    logic [3:0]  probe_index;
    logic        probe_valid;
    logic        rd_req;
    logic [31:0] rd_entryhi;
    logic [31:0] rd_entrylo0;
    logic [31:0] rd_entrylo1;
    logic        rd_valid;
    logic [3:0]  random_o;

    tlb_unit #(.ENTRIES(E), .ASID_W(8)) dut (
        .clk(clk), .rst(rst),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_store(lk_store), .asid_i(asid_i),
        .lk_valid(lk_valid), .lk_paddr(lk_paddr), .lk_miss(lk_miss),
        .lk_invalid(lk_invalid), .lk_modified(lk_modified),
        .wr_en(wr_en), .wr_random(wr_random), .index_i(index_i),
        .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
        .wired_i(wired_i), .wired_we(wired_we),
        .probe_req(probe_req), .probe_miss(probe_miss), .probe_index(probe_index),
        .probe_valid(probe_valid),
        .rd_req(rd_req), .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0),
        .rd_entrylo1(rd_entrylo1), .rd_valid(rd_valid),
        .random_o(random_o)
    );

    always #5 clk = ~clk;

    // Reference state: raw register images written into each slot.
    logic [31:0] m_hi  [E];
    logic [31:0] m_lo0 [E];
    logic [31:0] m_lo1 [E];
    bit          m_used[E];
    int          m_rnd;

    logic        e_lk_v, e_lk_miss, e_lk_inv, e_lk_mod;
    logic [31:0] e_lk_pa;
    logic        e_pb_v, e_pb_miss;
    logic [3:0]  e_pb_idx;
    logic        e_rd_v;
    logic [31:0] e_rd_hi, e_rd_lo0, e_rd_lo1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int find_entry(input logic [31:0] hi_key, input logic [7:0] as);
        for (int i = 0; i < E; i++) begin
            if (m_used[i] && m_hi[i][31:13] == hi_key[31:13] &&
                ((m_lo0[i][0] && m_lo1[i][0]) || m_hi[i][7:0] == as))
                return i;
        end
        return -1;
    endfunction

    task automatic model_lookup(input logic [31:0] va, input logic st, input logic [7:0] as);
        int hit;
        logic [31:0] lo;
        e_lk_pa = 0; e_lk_miss = 0; e_lk_inv = 0; e_lk_mod = 0;
        if (va >= 32'h8000_0000) begin
            e_lk_pa = va & 32'h1FFF_FFFF;
            return;
        end
        hit = find_entry(va, as);
        if (hit < 0) begin
            e_lk_miss = 1;
            return;
        end
        lo = va[12] ? m_lo1[hit] : m_lo0[hit];
`ifdef TLB_PERM_CHECK_EN
        e_lk_inv = !lo[1];
        e_lk_mod = st && lo[1] && !lo[2];
        if (e_lk_inv || e_lk_mod) return;
`else
        if (st) e_lk_pa = 0;
`endif
        e_lk_pa = (lo[25:6] << 12) | (va & 32'hFFF);
    endtask

    task automatic model_read(input int idx);
        logic g;
        e_rd_hi = 0; e_rd_lo0 = 0; e_rd_lo1 = 0;
        if (!m_used[idx]) return;
        g = m_lo0[idx][0] & m_lo1[idx][0];
        e_rd_hi  = (m_hi[idx] & 32'hFFFF_E000) | (m_hi[idx] & 32'hFF);
        e_rd_lo0 = (m_lo0[idx] & 32'h03FF_FFFE) | 32'(g);
        e_rd_lo1 = (m_lo1[idx] & 32'h03FF_FFFE) | 32'(g);
    endtask

    // One clock: predict from the pre-edge model, step the model, check outputs.
    task automatic tick();
        int widx, p;
        if (rst) begin
            e_lk_v = 0; e_lk_pa = 0; e_lk_miss = 0; e_lk_inv = 0; e_lk_mod = 0;
            e_pb_v = 0; e_pb_miss = 0; e_pb_idx = 0;
            e_rd_v = 0; e_rd_hi = 0; e_rd_lo0 = 0; e_rd_lo1 = 0;
        end else begin
            e_lk_v = lk_req;
            if (lk_req) model_lookup(lk_vaddr, lk_store, asid_i);
            e_pb_v = probe_req;
            if (probe_req) begin
                p = find_entry(entryhi_i, entryhi_i[7:0]);
                e_pb_miss = (p < 0);
                e_pb_idx  = (p < 0) ? 4'd0 : 4'(p);
            end
            e_rd_v = rd_req;
            if (rd_req) model_read(int'(index_i));
        end
        widx = wr_random ? m_rnd : int'(index_i);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < E; i++) m_used[i] = 0;
            m_rnd = E - 1;
        end else begin
            if (wr_en) begin
                m_used[widx] = 1;
                m_hi[widx]   = entryhi_i;
                m_lo0[widx]  = entrylo0_i;
                m_lo1[widx]  = entrylo1_i;
            end
            if (wired_we || m_rnd <= int'(wired_i)) m_rnd = E - 1;
            else m_rnd = m_rnd - 1;
        end
        chk("random_o", 32'(random_o), 32'(m_rnd));
        chk("lk_valid", 32'(lk_valid), 32'(e_lk_v));
        chk("lk_paddr", lk_paddr, e_lk_pa);
        chk("lk_miss", 32'(lk_miss), 32'(e_lk_miss));
        chk("lk_invalid", 32'(lk_invalid), 32'(e_lk_inv));
        chk("lk_modified", 32'(lk_modified), 32'(e_lk_mod));
        chk("probe_valid", 32'(probe_valid), 32'(e_pb_v));
        chk("probe_miss", 32'(probe_miss), 32'(e_pb_miss));
        if (e_pb_v && !e_pb_miss) chk("probe_index", 32'(probe_index), 32'(e_pb_idx));
        chk("rd_valid", 32'(rd_valid), 32'(e_rd_v));
        chk("rd_entryhi", rd_entryhi, e_rd_hi);
        chk("rd_entrylo0", rd_entrylo0, e_rd_lo0);
        chk("rd_entrylo1", rd_entrylo1, e_rd_lo1);
    endtask

    task automatic quiet();
        lk_req = 0; wr_en = 0; wr_random = 0; probe_req = 0; rd_req = 0;
        wired_we = 0; lk_store = 0;
    endtask

    task automatic set_write(input logic [31:0] hi, input logic [31:0] l0,
                             input logic [31:0] l1, input logic [3:0] idx, input logic rnd);
        wr_en = 1; wr_random = rnd; index_i = idx;
        entryhi_i = hi; entrylo0_i = l0; entrylo1_i = l1;
    endtask

    logic [18:0] vpn_pool [4];
    int          saved_rnd;

    initial begin
        vpn_pool[0] = 19'h00200; vpn_pool[1] = 19'h00300;
        vpn_pool[2] = 19'h12345; vpn_pool[3] = 19'h00500;
        for (int i = 0; i < E; i++) begin
            m_used[i] = 0; m_hi[i] = 0; m_lo0[i] = 0; m_lo1[i] = 0;
        end
        m_rnd = E - 1;
        rst = 1; quiet();
        lk_vaddr = 0; asid_i = 0; index_i = 0; entryhi_i = 0;
        entrylo0_i = 0; entrylo1_i = 0; wired_i = 0;
        tick(); tick();
        chk("reset_random", 32'(random_o), 32'd15);
        rst = 0;

        // Refill miss, then unmapped bypass.
        lk_req = 1; lk_vaddr = 32'h0040_0000; tick();
        chk("miss_flag", 32'(lk_miss), 32'd1);
        lk_vaddr = 32'h8000_1234; tick();
        chk("unmapped_pa", lk_paddr, 32'h0000_1234);
        quiet();

        // Global entry at index 3, odd page from a foreign ASID.
        set_write(32'h0040_0005, 32'h0000_0107, 32'h0000_0147, 4'd3, 0); tick();
        quiet(); lk_req = 1; lk_vaddr = 32'h0040_1ABC; asid_i = 8'h09; tick();
        chk("global_odd_pa", lk_paddr, 32'h0000_5ABC);

        // Non-global rewrite: ASID decides.
        quiet(); set_write(32'h0040_0005, 32'h0000_0106, 32'h0000_0146, 4'd3, 0); tick();
        quiet(); lk_req = 1; asid_i = 8'h05; tick();
        chk("asid_hit_pa", lk_paddr, 32'h0000_5ABC);
        asid_i = 8'h06; tick();
        chk("asid_miss", 32'(lk_miss), 32'd1);
        quiet(); probe_req = 1; entryhi_i = 32'h0040_0005; tick();
        chk("probe_idx3", 32'(probe_index), 32'd3);
        chk("probe_hit", 32'(probe_miss), 32'd0);
        quiet(); rd_req = 1; index_i = 4'd3; tick();
        chk("tlbr_hi", rd_entryhi, 32'h0040_0005);

        // Random with Wired=4, a Wired write mid-sequence, then TLBWR/TLBR.
        quiet(); wired_i = 4'd4;
        for (int i = 0; i < 14; i++) tick();
        wired_we = 1; tick();
        chk("wired_we_reload", 32'(random_o), 32'd15);
        wired_we = 0;
        for (int i = 0; i < 5; i++) tick();
        saved_rnd = m_rnd;
        set_write(32'h2468_A011, 32'h0000_0C87, 32'h0000_0CC6, 4'd0, 1); tick();
        quiet(); rd_req = 1; index_i = 4'(saved_rnd); tick();
        chk("tlbwr_hi", rd_entryhi, 32'h2468_A011);
        chk("tlbwr_lo1", rd_entrylo1, 32'h0000_0CC6);

        // Same-cycle write and lookup sees the old contents.
        quiet(); set_write(32'h0060_0000, 32'h0000_0207, 32'h0000_0247, 4'd5, 0);
        lk_req = 1; lk_vaddr = 32'h0060_0010; asid_i = 8'h00; tick();
        chk("same_cycle_miss", 32'(lk_miss), 32'd1);
        wr_en = 0; tick();
        chk("next_cycle_hit", lk_paddr, 32'h0000_8010);

        // Permission pages: even V=1 D=0, odd V=0.
        quiet(); set_write(32'h00A0_0000, 32'h0000_01C3, 32'h0000_0205, 4'd6, 0); tick();
        quiet(); lk_req = 1; lk_vaddr = 32'h00A0_0100; lk_store = 1; tick();
`ifdef TLB_PERM_CHECK_EN
        chk("store_modified", 32'(lk_modified), 32'd1);
        chk("store_pa_zero", lk_paddr, 32'd0);
`endif
        lk_store = 0; tick();
        chk("load_pa", lk_paddr, 32'h0000_7100);
        lk_vaddr = 32'h00A0_1100; tick();
`ifdef TLB_PERM_CHECK_EN
        chk("invalid_flag", 32'(lk_invalid), 32'd1);
`else
        chk("invalid_ignored_pa", lk_paddr, 32'h0000_8100);
`endif

        // Reset mid-operation drops in-flight results.
        quiet(); lk_req = 1; probe_req = 1; rd_req = 1; rst = 1; tick();
        rst = 0; quiet(); tick();

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            quiet();
            rst       = ($urandom_range(0, 99) == 0);
            lk_req    = ($urandom_range(0, 3) != 0);
            lk_store  = $urandom_range(0, 1);
            lk_vaddr  = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h8000_0000)
                        : {vpn_pool[$urandom_range(0, 3)], 13'($urandom())};
            asid_i    = 8'($urandom_range(0, 3));
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_random = $urandom_range(0, 1);
            index_i   = 4'($urandom_range(0, 15));
            entryhi_i = {vpn_pool[$urandom_range(0, 3)], 5'($urandom()), 8'($urandom_range(0, 3))};
            entrylo0_i = $urandom();
            entrylo1_i = $urandom();
            probe_req = $urandom_range(0, 1);
            rd_req    = $urandom_range(0, 1);
            wired_we  = ($urandom_range(0, 19) == 0);
            if (wired_we) wired_i = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
